// File: rtl/gray_to_bin_serial.sv
// Serial Gray-to-binary decoder that resolves one bit per clock, MSB first.
// Results are published only once complete. busy and done are registered.
module gray_to_bin_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH - 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gray_q  <= {WIDTH{1'b0}};
      bin_q   <= {WIDTH{1'b0}};
      dout_q  <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gray_q  <= gray_d;
      bin_q   <= bin_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d = state_q;
    gray_d  = gray_q;
    bin_d   = bin_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          gray_d  = data_in;
          bin_d   = {data_in[WIDTH-1], {(WIDTH-1){1'b0}}};
          cnt_d   = CW'(WIDTH - 2);
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        // Each bit folds in the already-resolved bit above it
        for (int i = 0; i < WIDTH - 1; i++) begin
          if (cnt_q == CW'(i)) begin
            bin_d[i] = bin_q[i+1] ^ gray_q[i];
          end else begin
            bin_d[i] = bin_q[i];
          end
        end
        if (cnt_q == {CW{1'b0}}) begin
          dout_d  = bin_d;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          state_d = CONV;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == CONV);
    done_d = (state_d == DONE);
  end

  assign data_out = dout_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_gray_to_bin_serial.sv
// Bench for gray_to_bin_serial: a timeline model checked every cycle, plus directed cases.
// A second instance exercises WIDTH=2.
module tb_gray_to_bin_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] data_in, data_out;
  logic         busy, done;
  logic         start2;
  logic [1:0]   din2, dout2;
  logic         busy2, done2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gray_to_bin_serial #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .data_out(data_out), .busy(busy), .done(done)
  );

  gray_to_bin_serial #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .data_in(din2),
    .data_out(dout2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Binary bit i is the XOR of all Gray bits at or above i
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  // Model: an operand accepted at edge k yields busy after edges k..k+W-2,
  // done after edge k+W-1 and a free IDLE from edge k+W+1 onwards
  int           n_cnt    = 0;
  int           m_acc    = 0;
  bit           m_active = 1'b0;
  logic [W-1:0] m_cap    = 8'h00;
  logic [W-1:0] m_dout   = 8'h00;
  bit           chk_en   = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_active <= 1'b0;
      m_dout   <= 8'h00;
    end else begin
      if (m_active && (n_cnt - m_acc == W - 1)) m_dout <= g2b(m_cap);
      if ((!m_active || (n_cnt - m_acc >= W + 1)) && start) begin
        m_acc    <= n_cnt;
        m_cap    <= data_in;
        m_active <= 1'b1;
      end
    end
    n_cnt <= n_cnt + 1;
  end

  always @(negedge clk) begin
    int d;
    bit eb, ed;
    if (chk_en) begin
      d  = (n_cnt - 1) - m_acc;
      eb = m_active && (d >= 0) && (d <= W - 2);
      ed = m_active && (d == W - 1);
      chk("model data_out", 32'(data_out), 32'(m_dout));
      chk("model busy", 32'(busy), 32'(eb));
      chk("model done", 32'(done), 32'(ed));
    end
  end

  task automatic run_op(input logic [W-1:0] g, input logic [W-1:0] exp, input string nm);
    int lat;
    int bc;
    @(negedge clk);
    start   = 1'b1;
    data_in = g;
    @(negedge clk);
    start   = 1'b0;
    data_in = 8'($urandom);
    lat = 0;
    bc  = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
    end
    chk({nm, " latency"}, 32'(lat), 32'd7);
    chk({nm, " busy cycles"}, 32'(bc), 32'd7);
    chk({nm, " data_out"}, 32'(data_out), 32'(exp));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] g2 [4];
    logic [1:0] e2 [4];
    int nd;
    g2 = '{2'b11, 2'b00, 2'b01, 2'b10};
    e2 = '{2'b10, 2'b00, 2'b01, 2'b11};

    reset   = 1'b1;
    start   = 1'b1;
    data_in = 8'hFF;
    start2  = 1'b1;
    din2    = 2'b11;
    repeat (3) @(negedge clk);
    chk("reset data_out", 32'(data_out), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset w2 data_out", 32'(dout2), 32'h0);
    reset  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    chk_en = 1'b1;

    // WIDTH=2 instance
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start2 = 1'b1;
      din2   = g2[i];
      @(negedge clk);
      start2 = 1'b0;
      din2   = 2'($urandom);
      chk("w2 busy", 32'(busy2), 32'h1);
      chk("w2 early done", 32'(done2), 32'h0);
      @(negedge clk);
      chk("w2 done", 32'(done2), 32'h1);
      chk("w2 busy after", 32'(busy2), 32'h0);
      chk("w2 data_out", 32'(dout2), 32'(e2[i]));
      @(negedge clk);
      chk("w2 done width", 32'(done2), 32'h0);
    end

    // Basic decode cases
    run_op(8'h00, 8'h00, "g00");
    run_op(8'hFF, 8'hAA, "gFF");
    run_op(8'h80, 8'hFF, "g80");
    run_op(8'hC0, 8'h80, "gC0");
    run_op(8'h77, 8'h5A, "g77");

    // Hold after the 8'h5A result
    repeat (20) begin
      data_in = 8'($urandom);
      @(negedge clk);
      chk("hold data_out", 32'(data_out), 32'h5A);
      chk("hold done", 32'(done), 32'h0);
    end

    // Exhaustive, back to back
    for (int b = 0; b < 256; b++) begin
      run_op(8'(b) ^ (8'(b) >> 1), 8'(b), "exh");
    end

    // start held high with data_in churning
    @(negedge clk);
    start   = 1'b1;
    data_in = 8'($urandom);
    nd = 0;
    for (int i = 0; i < 45; i++) begin
      data_in = 8'($urandom);
      @(negedge clk);
      if (done) nd++;
    end
    start = 1'b0;
    chk("held start done count", 32'(nd), 32'd5);
    repeat (10) @(negedge clk);

    // Reset three edges into a conversion, with start on the reset edge
    start   = 1'b1;
    data_in = 8'hFF;
    @(negedge clk);
    start   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b1;
    start   = 1'b1;
    data_in = 8'h3C;
    @(negedge clk);
    reset   = 1'b0;
    start   = 1'b0;
    chk("midreset busy", 32'(busy), 32'h0);
    chk("midreset done", 32'(done), 32'h0);
    chk("midreset data_out", 32'(data_out), 32'h0);
    repeat (15) begin
      @(negedge clk);
      chk("midreset no done", 32'(done), 32'h0);
    end

    // Random traffic with occasional resets
    repeat (600) begin
      @(negedge clk);
      reset   = ($urandom_range(0, 49) == 0);
      start   = ($urandom_range(0, 2) == 0);
      data_in = 8'($urandom);
    end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_to_bin_serial.md
GRAY_TO_BIN_SERIAL -- requirements
Module: gray_to_bin_serial

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter WIDTH, default 8, data width in bits; the block SHALL support any WIDTH >= 2.
REQ-003 Port clk, input, 1, rising-edge clock for all state.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port start, input, 1, one-cycle request to decode data_in.
REQ-006 Port data_in, input, WIDTH, Gray-coded operand, sampled only on the accepting start edge.
REQ-007 Port data_out, output, WIDTH, registered binary result.
REQ-008 Port busy, output, 1, high while a conversion is in progress.
REQ-009 Port done, output, 1, one-cycle pulse marking a valid new data_out.

Function
REQ-010 The FSM SHALL have three states: IDLE, CONV and DONE.
REQ-011 In IDLE with start=1 at edge k, the block SHALL:
- capture data_in into the internal Gray register;
- set binary bit [WIDTH-1] = data_in[WIDTH-1] (MSB copy);
- load the bit counter with WIDTH-2;
- enter CONV.
REQ-012 In CONV, each edge SHALL compute bin[cnt] = bin[cnt+1] XOR gray[cnt].
REQ-013 In CONV, if cnt != 0 the counter SHALL decrement; if cnt == 0 the FSM SHALL enter DONE.
REQ-014 data_out SHALL load the complete WIDTH-bit result only on the edge entering DONE (edge k+WIDTH-1).
REQ-015 data_out SHALL hold its value at all other times and never show partial results.
REQ-016 done SHALL be 1 only while in DONE, for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-017 busy SHALL be 1 only while in CONV (edges k+1 .. k+WIDTH-1 inclusive, i.e. WIDTH-1 cycles).
REQ-018 start SHALL be ignored in CONV and DONE; no queuing; data_in changes there SHALL have no effect.
REQ-019 start asserted in the IDLE cycle immediately after DONE SHALL be accepted normally (back-to-back throughput WIDTH+1 cycles per operand).
REQ-020 Latency SHALL be fixed: done rises WIDTH-1 edges after the accepting start edge, independent of data value.
REQ-021 Counter width SHALL be clog2(WIDTH-1) bits, minimum 1; it SHALL never wrap below 0.
REQ-022 The result SHALL equal the unique binary b with b XOR (b>>1) == captured Gray value.

Reset
REQ-023 With reset=1 at an edge, the block SHALL set: state IDLE, data_out = 0, done = 0, busy = 0, internal Gray/binary registers = 0, counter = 0.
REQ-024 Reset SHALL take priority over start and over any state, including mid-CONV and DONE.
REQ-025 After reset, no done pulse SHALL occur for the aborted operation.
REQ-026 start sampled on the same edge as reset=1 SHALL be discarded.

Verification
REQ-027 The bench SHALL cover these basic decode cases:
- start, data_in=8'h00 -> done at edge k+7, data_out=8'h00;
- 8'hFF -> 8'hAA;
- 8'h80 -> 8'hFF;
- 8'hC0 -> 8'h80;
- 8'h77 -> 8'h5A.
REQ-028 Exhaustive run: all 256 binary values b, drive Gray b^(b>>1) -> data_out == b for each, done pulse width exactly 1, busy high exactly 7 cycles per operand.
REQ-029 Ignored start: start held high continuously with data_in toggling during CONV -> one done per WIDTH+1 cycles; each result matches data_in captured at its accepting edge only.
REQ-030 Mid-operation reset: start with 8'hFF, assert reset 3 edges later -> next cycle busy=0, done=0, data_out=8'h00; no done afterwards until a new start.
REQ-031 Hold check: after done with result 8'h5A, idle 20 cycles with data_in random -> data_out stays 8'h5A, done stays 0.
REQ-032 Parameter check with WIDTH=2: Gray 2'b11 -> 2'b10; done exactly 1 edge after start; busy high 1 cycle.
